dac_i2s_sequencer: RTL

Sequences the board's serial audio DAC: divides the system clock into BCLK/LRCLK, accepts stereo samples from the sound mixer through a one-entry valid/ready holding register, and shifts them out MSB-first in I2S framing. Sits between the mixer output and the DAC pins in the board top. CONFIG_BOARD supplies the divider and width values (DAC_BIT_WIDTH, DAC_BCLK_DIV).

---
 rtl/dac_i2s_sequencer_pkg.sv | 24 ++
 rtl/dac_bclk_divider.sv | 37 +++
 rtl/dac_i2s_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dac_i2s_sequencer_pkg.sv
// Shared types and helpers for the I2S DAC sequencer.
// The board-level defaults live here so the top picks them up without extra plumbing.
package dac_i2s_sequencer_pkg;

    localparam int DAC_BIT_WIDTH = 10;
    localparam int DAC_SLOT_BITS = 16;
    localparam int DAC_BCLK_DIV  = 38;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } dac_state_e;

    // BCLK periods in one stereo frame (left slot + right slot).
    function automatic int frame_bits(input int slot_bits);
        return 2 * slot_bits;
    endfunction

    // Zero bits appended after each sample to fill its slot.
    function automatic int slot_pad_bits(input int bit_width, input int slot_bits);
        return slot_bits - bit_width;
    endfunction

endpackage

// File: rtl/dac_bclk_divider.sv
// Divides the system clock into BCLK and flags the BCLK falling edge one cycle early.
// Held cleared while not enabled so every run starts from the same phase.
module dac_bclk_divider #(
    parameter int BCLK_DIV = 38
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic bclk,
    output logic fall_tick
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(BCLK_DIV - 1);

    logic [DW-1:0] d;
    logic          tick;

    assign tick      = enable && (d == D_LAST);
    assign fall_tick = tick && bclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d    <= '0;
            bclk <= 1'b0;
        end else if (!enable) begin
            d    <= '0;
            bclk <= 1'b0;
        end else if (tick) begin
            d    <= '0;
            bclk <= ~bclk;
        end else begin
            d    <= d + 1'b1;
        end
    end

endmodule

// File: rtl/dac_i2s_sequencer.sv
// I2S DAC sequencer: BCLK/LRCLK generation, one-entry sample holding register, MSB-first shifter.
// Handshake: a pair transfers on any CLK edge where IN_VALID and IN_READY are both high.
module dac_i2s_sequencer
    import dac_i2s_sequencer_pkg::*;
#(
    parameter int BIT_WIDTH = DAC_BIT_WIDTH,
    parameter int SLOT_BITS = DAC_SLOT_BITS,
    parameter int BCLK_DIV  = DAC_BCLK_DIV
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic                 EN,
    input  logic [BIT_WIDTH-1:0] IN_L,
    input  logic [BIT_WIDTH-1:0] IN_R,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic                 DAC_BCLK,
    output logic                 DAC_LRCLK,
    output logic                 DAC_DATA,
    output logic                 BUSY,
    output logic                 UNDERRUN,
    output dac_state_e           DBG_STATE
);

    localparam int FRAME = frame_bits(SLOT_BITS);
    localparam int PAD   = slot_pad_bits(BIT_WIDTH, SLOT_BITS);
    localparam int BW    = $clog2(FRAME);
    localparam logic [BW-1:0] B_LAST  = BW'(FRAME - 1);
    localparam logic [BW-1:0] B_RIGHT = BW'(SLOT_BITS);
    localparam logic [BW-1:0] B_LOAD  = BW'(1);

    dac_state_e state;
    dac_state_e state_next;

    logic                 bclk;
    logic                 fall_tick;
    logic [BW-1:0]        b;
    logic [BW-1:0]        b_next;
    logic [FRAME-1:0]     sr;
    logic [FRAME-1:0]     load_word;
    logic                 lrclk;
    logic                 data;
    logic                 load;
    logic                 frame_end;
    logic [BIT_WIDTH-1:0] hold_l;
    logic [BIT_WIDTH-1:0] hold_r;
    logic [BIT_WIDTH-1:0] last_l;
    logic [BIT_WIDTH-1:0] last_r;
    logic [BIT_WIDTH-1:0] load_l;
    logic [BIT_WIDTH-1:0] load_r;
    logic                 empty;
    logic                 underrun;

    dac_bclk_divider #(
        .BCLK_DIV (BCLK_DIV)
    ) u_divider (
        .clk       (CLK),
        .rst_n     (RESET_n),
        .enable    (state == RUN),
        .bclk      (bclk),
        .fall_tick (fall_tick)
    );

    // Frame position and load decode.
    always_comb begin
        b_next    = (b == B_LAST) ? '0 : b + 1'b1;
        load      = (state == RUN) && fall_tick && (b_next == B_LOAD);
        frame_end = (state == RUN) && fall_tick && (b_next == '0);
        load_l    = empty ? last_l : hold_l;
        load_r    = empty ? last_r : hold_r;
        load_word = (FRAME'(load_l) << (FRAME - BIT_WIDTH)) | (FRAME'(load_r) << PAD);
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stopping is only honoured on the frame boundary, so a late EN pulse cannot cut a frame short.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (EN) state_next = RUN;
            RUN:     if (frame_end && !EN) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        BUSY      = (state == RUN);
        DBG_STATE = state;
        IN_READY  = empty;
        DAC_BCLK  = bclk;
        DAC_LRCLK = lrclk;
        DAC_DATA  = data;
        UNDERRUN  = underrun;
    end

    // Serial side: LRCLK follows the slot, data trails it by one BCLK.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            b     <= '0;
            lrclk <= 1'b0;
            data  <= 1'b0;
            sr    <= '0;
        end else if (state == IDLE) begin
            b     <= '0;
            lrclk <= 1'b0;
            data  <= 1'b0;
        end else if (fall_tick) begin
            if (frame_end && !EN) begin
                b     <= '0;
                lrclk <= 1'b0;
                data  <= 1'b0;
            end else begin
                b     <= b_next;
                lrclk <= (b_next >= B_RIGHT);
                if (load) begin
                    sr   <= load_word;
                    data <= load_word[FRAME-1];
                end else begin
                    sr   <= {sr[FRAME-2:0], 1'b0};
                    data <= sr[FRAME-2];
                end
            end
        end
    end

    // Holding register: a load sees the flag as it was before any same-cycle capture.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            hold_l   <= '0;
            hold_r   <= '0;
            last_l   <= '0;
            last_r   <= '0;
            empty    <= 1'b1;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (load) begin
                if (empty) begin
                    underrun <= 1'b1;
                end else begin
                    last_l <= hold_l;
                    last_r <= hold_r;
                    empty  <= 1'b1;
                end
            end
            if (IN_VALID && empty) begin
                hold_l <= IN_L;
                hold_r <= IN_R;
                empty  <= 1'b0;
            end
        end
    end

endmodule
